// File: rtl/simon_score_display.sv
// simon_score_display: the display stage that sits after the Simon game core.
// It saturates the binary score to 0..99 and converts it to BCD with a
// sequential double-dabble. The result is committed to the tens/ones display
// registers in one step, and the two digits are time-multiplexed onto a shared
// 7-segment bus. Each digit slot starts with dead time to prevent ghosting.
module simon_score_display #(
  parameter int MUX_PERIOD = 256,
  parameter int DEAD       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] score,
  input  logic       score_valid,
  input  logic       enable,
  input  logic       seginv,
  output logic [6:0] seg,
  output logic [6:0] seg_oe,
  output logic       dig1,
  output logic       dig2,
  output logic       busy
);

  localparam int CW = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUX_PERIOD - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic          SLOT_TENS = 1'b0;
  localparam logic          SLOT_ONES = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  // Segment decode for one BCD digit, bit 0 = segment a.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Conversion and FSM state
  state_t     state_q,   state_d;
  logic [2:0] iter_q,    iter_d;
  logic [7:0] bcd_q,     bcd_d;
  logic [6:0] sh_q,      sh_d;
  logic [6:0] pend_q,    pend_d;
  logic       pend_v_q,  pend_v_d;
  logic [3:0] tens_q,    tens_d;
  logic [3:0] ones_q,    ones_d;
  logic       busy_q,    busy_d;

  // Multiplexer and output state
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          slot_q,   slot_d;
  logic [6:0]    seg_q,    seg_d;
  logic [6:0]    seg_oe_q, seg_oe_d;
  logic          dig1_q,   dig1_d;
  logic          dig2_q,   dig2_d;

  logic [6:0]  score_sat;
  logic [7:0]  adj;
  logic [14:0] shifted;
  logic        dead;
  logic        tens_on;
  logic        ones_on;
  logic [3:0]  digit;
  logic [6:0]  pattern;

  // Next state for the capture / double-dabble / commit sequence.
  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    bcd_d    = bcd_q;
    sh_d     = sh_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    busy_d   = busy_q;

    score_sat = (score > 7'd99) ? 7'd99 : score;

    // Add 3 to any nibble >= 5, then shift the BCD:binary pair left by one.
    adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;
    shifted = {adj, sh_q} << 1;

    case (state_q)
      S_IDLE: begin
        if (score_valid) begin
          sh_d    = score_sat;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d  = shifted[14:7];
        sh_d   = shifted[6:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd6) state_d = S_COMMIT;
        if (score_valid) begin
          pend_d   = score_sat;
          pend_v_d = 1'b1;
        end
      end
      S_COMMIT: begin
        tens_d   = bcd_q[7:4];
        ones_d   = bcd_q[3:0];
        pend_v_d = 1'b0;
        if (score_valid || pend_v_q) begin
          // A strobe on this edge is newer than anything held as pending.
          sh_d    = score_valid ? score_sat : pend_q;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Slot counter, digit selection, blanking and segment polarity.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    slot_d = (cnt_q == CNT_LAST) ? ~slot_q : slot_q;

    dead    = (cnt_q < CNT_DEAD);
    tens_on = enable && !dead && (slot_q == SLOT_TENS) && (tens_q != 4'd0);
    ones_on = enable && !dead && (slot_q == SLOT_ONES);
    digit   = (slot_q == SLOT_ONES) ? ones_q : tens_q;
    pattern = (tens_on || ones_on) ? digit_pattern(digit) : 7'h00;

    seg_d    = pattern ^ {7{seginv}};
    seg_oe_d = {7{enable}};
    dig1_d   = tens_on;
    dig2_d   = ones_on;
  end

  // All state registers, with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      bcd_q    <= '0;
      sh_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      slot_q   <= SLOT_TENS;
      seg_q    <= '0;
      seg_oe_q <= '0;
      dig1_q   <= 1'b0;
      dig2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      bcd_q    <= bcd_d;
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      seg_q    <= seg_d;
      seg_oe_q <= seg_oe_d;
      dig1_q   <= dig1_d;
      dig2_q   <= dig2_d;
    end
  end

  assign seg    = seg_q;
  assign seg_oe = seg_oe_q;
  assign dig1   = dig1_q;
  assign dig2   = dig2_q;
  assign busy   = busy_q;

endmodule

// File: doc/simon_score_display.md
Name: simon_score_display

Overview:
- Downstream display stage of the Simon game core.
- Takes the binary score and converts it to BCD with a sequential double-dabble.
- Time-multiplexes the two-digit 7-segment display: shared seg bus plus dig1/dig2 digit enables, with optional segment inversion for common-anode parts.
- Sits between the game FSM score output and the uo_out/uio_out pads.

Parameters:
- MUX_PERIOD, 256: clock cycles per digit slot. Must be >= DEAD+2.
- DEAD, 2: blanking cycles at the start of each slot (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- score  input  7  binary score, 0..127
- score_valid  input  1  one-cycle load strobe for score
- enable  input  1  display on; 0 blanks everything
- seginv  input  1  1 inverts seg polarity
- seg  output  7  segments, seg[0]=a .. seg[6]=g
- seg_oe  output  7  output enables for seg pads
- dig1  output  1  tens digit enable, active-high
- dig2  output  1  ones digit enable, active-high
- busy  output  1  conversion in progress

Behaviour:
- Reset: rst_n sampled low at a clk edge.
  - Outputs: seg=0, seg_oe=0, dig1=0, dig2=0, busy=0.
  - Internal: displayed tens=0, ones=0, pending cleared, mux counter=0, slot=tens, FSM=IDLE.
  - Reset during a conversion aborts it; no partial value is committed.
- Saturation: a captured score >99 is replaced by 99 before conversion.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: score_valid high at edge E0 → capture saturated score; go to CONV; busy=1 after E0.
  - CONV: 7 iterations on edges E1..E7. Each iteration adds 3 to any BCD nibble >=5, then shifts left one bit, MSB first. Uses an 8-bit BCD accumulator plus 7-bit shift register.
  - COMMIT: at edge E8, tens/ones display registers update atomically and busy=0.
  - Latency: strobe to display registers is 8 cycles.
- score_valid while not IDLE:
  - Value goes into a one-deep pending register; the newest value overwrites.
  - At COMMIT, if pending (or score_valid on that same edge), the next conversion starts: CONV entered at E8, busy stays 1.
  - Intermediate values are never displayed.
- Multiplexer:
  - Counter runs 0..MUX_PERIOD-1 continuously; the slot toggles tens↔ones at wrap.
  - Counter values 0..DEAD-1 in a slot: dig1=dig2=0.
  - Otherwise the slot's digit enable is 1 and the other is 0.
- Leading zero blanking: tens==0 → tens slot keeps dig1=0 and pattern=0. The ones digit always shows, including "0".
- Segment patterns (before inversion), digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Blank=00.
- Output registers:
  - seg = pattern XOR {7{seginv}}.
  - In dead time or blanked slots, pattern=00, so seg=7F when seginv=1.
  - seg, dig1, dig2 are registered: one cycle after the counter/display state they reflect.
- enable=0:
  - dig1=dig2=0, pattern=00, seg_oe=0, all registered.
  - Conversion and mux counting continue.
  - enable=1 gives seg_oe=7F.
- seginv change takes effect on the next registered seg update; no glitch handling required.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with score_valid=1 → seg=00, seg_oe=00, dig1=dig2=0, busy=0. After release with enable=1, ones slot shows 3F with dig2=1; tens slot has dig1=0.
- Score 42, seginv=0, enable=1, one-cycle strobe → busy=1 for exactly 8 cycles.
  - Tens slot: dig1=1, seg=66. Ones slot: dig2=1, seg=5B.
  - First 2 cycles of each slot: dig1=dig2=0, seg=00.
- Score 7 → tens slot dig1=0, seg=00; ones slot seg=07. Score 120 → saturates: both slots show 6F.
- seginv=1, score 80 → tens seg=00 (inverted 7F), ones seg=40. Dead time seg=7F. enable=0 → seg_oe=00, dig1=dig2=0.
- Strobes of 15, then 23 and 31 during busy → 15 displays, then exactly one more conversion; final display 31 (tens 4F, ones 06). busy high continuously for 16 cycles.
- Reset asserted at E4 of a score=55 conversion after 42 was displayed → tens=ones=0 after reset; 55 never appears.
